// File: rtl/dff_arb_pkg.sv
// Shared definitions for the shared-capture round-robin arbiter.
// Optional grant-lock feature is enabled with DFF_ARB_LOCK_EN.
package dff_arb_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   localparam int HOLD_MIN = 1;
   localparam int HOLD_MAX = 255;

   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dff_share_arbiter_rr_pick.sv
// Rotating priority picker: first set request at or after ptr, wrapping
// at N_REQ (which need not be a power of two).
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             any,
   output logic [ID_W-1:0]  sel
);

   int idx;

   // scan from ptr upwards, keep only the first hit
   always_comb begin
      any = 1'b0;
      sel = '0;
      idx = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!any && req[idx]) begin
            any = 1'b1;
            sel = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one capture flop among N_REQ requesters.
// Define DFF_ARB_LOCK_EN to add i_lock (winner keeps the grant).
module dff_share_arbiter
   import dff_arb_pkg::*;
#(
   parameter int  N_REQ       = 4,
   parameter int  HOLD_CYCLES = 2,
   localparam int ID_W        = id_w(N_REQ)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [N_REQ-1:0] i_req,
   input  logic [N_REQ-1:0] i_d,
`ifdef DFF_ARB_LOCK_EN
   input  logic [N_REQ-1:0] i_lock,
`endif
   output logic [N_REQ-1:0] o_gnt,
   output logic             o_q,
   output logic [ID_W-1:0]  o_q_id,
   output logic             o_q_valid
);

   localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);

   logic             state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  sel_q, sel_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             q_q, q_d;
   logic [ID_W-1:0]  qid_q, qid_d;
   logic             qv_q, qv_d;

   logic             pick_any;
   logic [ID_W-1:0]  pick_sel;
   logic             sel_req;
   logic             cnt_zero;
   logic             lock_hit;
   logic [ID_W-1:0]  ptr_nxt;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req (i_req),
      .ptr (ptr_q),
      .any (pick_any),
      .sel (pick_sel)
   );

   assign sel_req  = i_req[sel_q];
   assign cnt_zero = (cnt_q == 8'd0);
   assign ptr_nxt  = (sel_q == ID_W'(N_REQ - 1)) ? '0 : sel_q + ID_W'(1);

`ifdef DFF_ARB_LOCK_EN
   assign lock_hit = i_lock[sel_q];
`else
   assign lock_hit = 1'b0;
`endif

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         q_q     <= 1'b0;
         qid_q   <= '0;
         qv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         q_q     <= q_d;
         qid_q   <= qid_d;
         qv_q    <= qv_d;
      end
   end

   // next state: grant on any request, release on abort or unlocked completion
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) state_d = ST_BUSY;
         end
         default: begin
            if (!sel_req)                  state_d = ST_IDLE;
            else if (cnt_zero && !lock_hit) state_d = ST_IDLE;
         end
      endcase
   end

   // register updates for grant, hold counter, pointer and capture
   always_comb begin
      cnt_d = cnt_q;
      ptr_d = ptr_q;
      sel_d = sel_q;
      gnt_d = gnt_q;
      q_d   = q_q;
      qid_d = qid_q;
      qv_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               sel_d = pick_sel;
               gnt_d = N_REQ'(1) << pick_sel;
               cnt_d = HOLD_LD;
            end
         end
         default: begin
            if (!sel_req) begin
               gnt_d = '0;
               ptr_d = ptr_nxt;
            end else if (!cnt_zero) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               q_d   = i_d[sel_q];
               qid_d = sel_q;
               qv_d  = 1'b1;
               if (lock_hit) begin
                  cnt_d = HOLD_LD;
               end else begin
                  gnt_d = '0;
                  ptr_d = ptr_nxt;
               end
            end
         end
      endcase
   end

   assign o_gnt     = gnt_q;
   assign o_q       = q_q;
   assign o_q_id    = qid_q;
   assign o_q_valid = qv_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter (N_REQ=4 and N_REQ=3 instances).
// Lock scenario is compiled in only when DFF_ARB_LOCK_EN is defined.
module tb_dff_share_arbiter;

   localparam int N    = 4;
   localparam int HOLD = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req, d, lock;
   logic [3:0]   gnt;
   logic         q;
   logic [1:0]   qid;
   logic         qv;
   logic [2:0]   req3, d3, lock3;
   logic [2:0]   gnt3;
   logic         q3;
   logic [1:0]   qid3;
   logic         qv3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dff_share_arbiter #(.N_REQ(4), .HOLD_CYCLES(HOLD)) u_dut (
      .i_clk     (clk),
      .i_reset   (rst_n),
      .i_req     (req),
      .i_d       (d),
`ifdef DFF_ARB_LOCK_EN
      .i_lock    (lock),
`endif
      .o_gnt     (gnt),
      .o_q       (q),
      .o_q_id    (qid),
      .o_q_valid (qv)
   );

   dff_share_arbiter #(.N_REQ(3), .HOLD_CYCLES(HOLD)) u_dut3 (
      .i_clk     (clk),
      .i_reset   (rst_n),
      .i_req     (req3),
      .i_d       (d3),
`ifdef DFF_ARB_LOCK_EN
      .i_lock    (lock3),
`endif
      .o_gnt     (gnt3),
      .o_q       (q3),
      .o_q_id    (qid3),
      .o_q_valid (qv3)
   );

   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic [3:0] d;
      logic [3:0] gnt;
      logic       q;
      logic [1:0] id;
      logic       v;
   } vec_t;

   vec_t tbl[21];

   // reference model state: owner=-1 means no grant outstanding
   int m_own, m_held, m_ptr;
   logic m_q, m_v;
   int m_id;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] eg,
                      input logic eq, input logic [1:0] eid, input logic ev);
      checks++;
      if (gnt !== eg || q !== eq || qid !== eid || qv !== ev) begin
         failures++;
         $display("FAIL %s got gnt=%b q=%b id=%0d v=%b want gnt=%b q=%b id=%0d v=%b",
                  nm, gnt, q, qid, qv, eg, eq, eid, ev);
      end
   endtask

   task automatic chk3(input string nm, input logic [2:0] eg,
                       input logic [1:0] eid, input logic ev);
      checks++;
      if (gnt3 !== eg || qid3 !== eid || qv3 !== ev) begin
         failures++;
         $display("FAIL %s got gnt=%b id=%0d v=%b want gnt=%b id=%0d v=%b",
                  nm, gnt3, qid3, qv3, eg, eid, ev);
      end
   endtask

   // one clock of arbiter behaviour from the rules, on plain integers
   task automatic model_step(input logic r, input logic [3:0] rq,
                             input logic [3:0] dd);
      if (!r) begin
         m_own = -1; m_held = 0; m_ptr = 0;
         m_q = 1'b0; m_id = 0; m_v = 1'b0;
      end else begin
         m_v = 1'b0;
         if (m_own < 0) begin
            for (int k = 0; k < N; k++) begin
               int c;
               c = (m_ptr + k) % N;
               if (m_own < 0 && rq[c]) m_own = c;
            end
            m_held = 1;
         end else if (!rq[m_own]) begin
            m_ptr = (m_own + 1) % N;
            m_own = -1;
         end else if (m_held == HOLD) begin
            m_q = dd[m_own];
            m_id = m_own;
            m_v = 1'b1;
            m_ptr = (m_own + 1) % N;
            m_own = -1;
         end else begin
            m_held++;
         end
      end
   endtask

   function automatic logic [3:0] m_gnt();
      logic [3:0] g;
      g = '0;
      if (m_own >= 0) g[m_own] = 1'b1;
      return g;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req = '0; d = '0; lock = '0;
      req3 = '0; d3 = '0; lock3 = '0;

      tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
      tbl[1]  = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0};
      tbl[2]  = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0};
      tbl[3]  = '{1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b1};
      tbl[4]  = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
      tbl[5]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
      tbl[6]  = '{1'b1, 4'b1111, 4'b1010, 4'b0001, 1'b0, 2'd0, 1'b0};
      tbl[7]  = '{1'b1, 4'b1111, 4'b1010, 4'b0001, 1'b0, 2'd0, 1'b0};
      tbl[8]  = '{1'b1, 4'b1111, 4'b1010, 4'b0000, 1'b0, 2'd0, 1'b1};
      tbl[9]  = '{1'b1, 4'b1111, 4'b1010, 4'b0010, 1'b0, 2'd0, 1'b0};
      tbl[10] = '{1'b1, 4'b1111, 4'b1010, 4'b0010, 1'b0, 2'd0, 1'b0};
      tbl[11] = '{1'b1, 4'b1111, 4'b1010, 4'b0000, 1'b1, 2'd1, 1'b1};
      tbl[12] = '{1'b1, 4'b1111, 4'b1010, 4'b0100, 1'b1, 2'd1, 1'b0};
      tbl[13] = '{1'b1, 4'b1111, 4'b1010, 4'b0100, 1'b1, 2'd1, 1'b0};
      tbl[14] = '{1'b1, 4'b1111, 4'b1010, 4'b0000, 1'b0, 2'd2, 1'b1};
      tbl[15] = '{1'b1, 4'b1111, 4'b1010, 4'b1000, 1'b0, 2'd2, 1'b0};
      tbl[16] = '{1'b1, 4'b1111, 4'b1010, 4'b1000, 1'b0, 2'd2, 1'b0};
      tbl[17] = '{1'b1, 4'b1111, 4'b1010, 4'b0000, 1'b1, 2'd3, 1'b1};
      tbl[18] = '{1'b1, 4'b1111, 4'b1010, 4'b0001, 1'b1, 2'd3, 1'b0};
      tbl[19] = '{1'b1, 4'b1111, 4'b1010, 4'b0001, 1'b1, 2'd3, 1'b0};
      tbl[20] = '{1'b1, 4'b1111, 4'b1010, 4'b0000, 1'b0, 2'd0, 1'b1};

      #2;
      for (int i = 0; i < 21; i++) begin
         rst_n = tbl[i].rst_n;
         req = tbl[i].req;
         d = tbl[i].d;
         tick();
         chk($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].q, tbl[i].id, tbl[i].v);
      end

      // abort: drop the granted request after one BUSY cycle
      req = '0; d = '0;
      do_reset();
      req = 4'b0011;
      tick();
      chk("abort_gnt", 4'b0001, 1'b0, 2'd0, 1'b0);
      req = 4'b0010;
      tick();
      chk("abort_drop", 4'b0000, 1'b0, 2'd0, 1'b0);
      tick();
      chk("abort_next", 4'b0010, 1'b0, 2'd0, 1'b0);

      // asynchronous reset while BUSY
      req = '0;
      do_reset();
      req = 4'b0100; d = 4'b0100;
      tick();
      chk("rst_pre", 4'b0100, 1'b0, 2'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_async", 4'b0000, 1'b0, 2'd0, 1'b0);
      req = 4'b1111;
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_first", 4'b0001, 1'b0, 2'd0, 1'b0);

      // non-power-of-two wrap on the 3-requester instance
      req = '0;
      do_reset();
      req3 = 3'b100;
      tick();
      chk3("n3_gnt2", 3'b100, 2'd0, 1'b0);
      tick();
      tick();
      chk3("n3_done2", 3'b000, 2'd2, 1'b1);
      req3 = 3'b101;
      tick();
      chk3("n3_wrap0", 3'b001, 2'd2, 1'b0);
      tick();
      tick();
      chk3("n3_done0", 3'b000, 2'd0, 1'b1);
      tick();
      chk3("n3_gnt2b", 3'b100, 2'd0, 1'b0);
      tick();
      tick();
      tick();
      chk3("n3_wrap0b", 3'b001, 2'd2, 1'b0);
      req3 = '0;

`ifdef DFF_ARB_LOCK_EN
      do_reset();
      req = 4'b0110; d = 4'b0100; lock = 4'b0100;
      repeat (3) tick();
      chk("lk_first1", 4'b0000, 1'b0, 2'd1, 1'b1);
      repeat (3) tick();
      chk("lk_hold_a", 4'b0100, 1'b1, 2'd2, 1'b1);
      repeat (2) tick();
      chk("lk_hold_b", 4'b0100, 1'b1, 2'd2, 1'b1);
      lock = '0;
      repeat (2) tick();
      chk("lk_release", 4'b0000, 1'b1, 2'd2, 1'b1);
      tick();
      chk("lk_next1", 4'b0010, 1'b1, 2'd2, 1'b0);
      lock = '0;
`endif

      // randomized traffic against the reference model
      req = '0; d = '0;
      rst_n = 1'b0;
      model_step(1'b0, req, d);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0) req = 4'($urandom);
         d = 4'($urandom);
         rst_n = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
         tick();
         model_step(rst_n, req, d);
         checks++;
         if (gnt !== m_gnt() || q !== m_q || qid !== 2'(m_id) || qv !== m_v) begin
            failures++;
            $display("FAIL rand%0d got gnt=%b q=%b id=%0d v=%b want gnt=%b q=%b id=%0d v=%b",
                     c, gnt, q, qid, qv, m_gnt(), m_q, m_id, m_v);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
